mac: RTL and testbench

MAC -- requirements
Module: mac

---
 rtl/mac_pkg.sv | 13 +
 rtl/mac_sat.sv | 39 +++
 rtl/mac.sv | 55 +++++
 tb/tb_mac.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared constants and fixed-point types for the MAC datapath.
// Operands and result are Q4.12, products Q8.24, accumulator Q16.24.
package mac_pkg;

    localparam int A_W    = 16;
    localparam int FRAC_W = 12;
    localparam int ACC_W  = 40;

    typedef logic signed [A_W-1:0]   operand_t;
    typedef logic signed [2*A_W-1:0] product_t;
    typedef logic signed [ACC_W-1:0] acc_t;

endpackage

// File: rtl/mac_sat.sv
// Reduces the Q16.24 accumulator to a Q4.12 result: floor shift by FRAC_W, then
// saturate (MAC_SAT_EN defined) or keep the low A_W bits (default build).
module mac_sat
    import mac_pkg::*;
#(
    parameter int A_W    = mac_pkg::A_W,
    parameter int FRAC_W = mac_pkg::FRAC_W,
    parameter int ACC_W  = mac_pkg::ACC_W
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [A_W-1:0]   out
);

    logic signed [ACC_W-1:0] shifted;

    // Arithmetic shift, so negative sums round toward minus infinity.
    assign shifted = acc >>> FRAC_W;

`ifdef MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-A_W+1){1'b0}}, {(A_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-A_W+1){1'b1}}, {(A_W-1){1'b0}}};

    // NOTE: every path starts from a default so no latch is inferred.
    always_comb begin
        out = shifted[A_W-1:0];
        if (shifted > MAX_V) begin
            out = {1'b0, {(A_W-1){1'b1}}};
        end else if (shifted < MIN_V) begin
            out = {1'b1, {(A_W-1){1'b0}}};
        end
    end
`else
    logic unused_shift_hi;

    assign out             = shifted[A_W-1:0];
    assign unused_shift_hi = ^shifted[ACC_W-1:A_W];
`endif

endmodule

// File: rtl/mac.sv
// Two-stage signed multiply-accumulate: registered Q8.24 product, then a
// free-running wrapping Q16.24 accumulator. Output reduction lives in mac_sat.
module mac
    import mac_pkg::*;
#(
    parameter int A_W    = mac_pkg::A_W,
    parameter int FRAC_W = mac_pkg::FRAC_W,
    parameter int ACC_W  = mac_pkg::ACC_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic signed [A_W-1:0] a,
    input  logic signed [A_W-1:0] b,
    output logic signed [A_W-1:0] out
);

    localparam int P_W = 2 * A_W;

    logic signed [P_W-1:0]   a_ext;
    logic signed [P_W-1:0]   b_ext;
    logic signed [P_W-1:0]   prod_d;
    logic signed [P_W-1:0]   prod_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_q;

    // Widen before multiplying so the full 2*A_W-bit product is kept.
    always_comb begin
        a_ext  = {{A_W{a[A_W-1]}}, a};
        b_ext  = {{A_W{b[A_W-1]}}, b};
        prod_d = a_ext * b_ext;
        acc_d  = acc_q + {{(ACC_W-P_W){prod_q[P_W-1]}}, prod_q};
    end

    // NOTE: state uses non-blocking assignments; reset clears both stages so
    // the first edge after release adds the zeroed product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
        end
    end

    mac_sat #(
        .A_W    (A_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_sat (
        .acc (acc_q),
        .out (out)
    );

endmodule

// File: tb/tb_mac.sv
// Directed bench for mac: hand-computed Q4.12 results checked with immediate
// assertions. Expected values follow MAC_SAT_EN when it is defined.
module tb_mac;
    import mac_pkg::*;

    logic     clk;
    logic     rst_n;
    operand_t a;
    operand_t b;
    operand_t out;

    int n_checks;
    int n_fail;

    mac dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input operand_t exp);
        n_checks++;
        assert (out === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, out, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset asserted and released between edges, clearing all history.
    task automatic restart(input operand_t a_v, input operand_t b_v);
        rst_n = 1'b0;
        #1;
        check("async_reset", 16'h0000);
        a     = a_v;
        b     = b_v;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        a        = 16'h5000;
        b        = 16'h5000;
        #2;
        check("reset_no_edge", 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_hold", 16'h0000);
        end

        // 1.0 * 1.0 accumulates one whole unit per edge after the pipeline fills.
        a     = 16'h1000;
        b     = 16'h1000;
        rst_n = 1'b1;
        tick(); check("one_e1", 16'h0000);
        tick(); check("one_e2", 16'h1000);
        tick(); check("one_e3", 16'h2000);
        tick(); check("one_e4", 16'h3000);

        // -2.0 * 3.0 = -6.0, then -12.0 which leaves the Q4.12 range.
        restart(16'hE000, 16'h3000);
        tick(); check("neg_e1", 16'h0000);
        tick(); check("neg_e2", 16'hA000);
        tick();
`ifdef MAC_SAT_EN
        check("neg_sat_lo", 16'h8000);
`else
        check("neg_wrap", 16'h4000);
`endif

        // 1/64 * 1/64 = exactly one output LSB per edge.
        restart(16'h0040, 16'h0040);
        tick(); check("lsb_e1", 16'h0000);
        tick(); check("lsb_e2", 16'h0001);
        tick(); check("lsb_e3", 16'h0002);
        tick(); check("lsb_e4", 16'h0003);

        // -1 LSB * 1 raw LSB: tiny negative product floors to -1 LSB.
        restart(16'hFFFF, 16'h0001);
        tick(); check("floor_e1", 16'h0000);
        tick(); check("floor_e2", 16'hFFFF);

        // 5.0 * 5.0 = 25.0 overflows the output range.
        restart(16'h5000, 16'h5000);
        tick(); check("big_e1", 16'h0000);
        tick();
`ifdef MAC_SAT_EN
        check("big_sat_hi", 16'h7FFF);
`else
        check("big_wrap", 16'h9000);
`endif

        // Reset dropped between edges mid-accumulation, released before the next edge.
        restart(16'h1000, 16'h1000);
        tick(); tick(); tick();
        check("mid_before", 16'h2000);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_async_clear", 16'h0000);
        #1;
        rst_n = 1'b1;
        tick(); check("mid_restart_e1", 16'h0000);
        tick(); check("mid_restart_e2", 16'h1000);

        // -8.0 * -8.0 adds 2^30 raw per edge; 512 additions wrap the 40-bit acc to -2^39.
        restart(16'h8000, 16'h8000);
        tick();
        for (int i = 0; i < 511; i++) tick();
`ifdef MAC_SAT_EN
        check("acc_pre_wrap", 16'h7FFF);
`else
        check("acc_pre_wrap", 16'h0000);
`endif
        tick();
`ifdef MAC_SAT_EN
        check("acc_wrapped", 16'h8000);
`else
        check("acc_wrapped", 16'h0000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
